// File: rtl/seq_gen1.sv
// Serial bit-pattern generator.
// Captures a pattern, its length and a repetition count when start is accepted.
// Shifts the pattern out MSB-first on x, one bit per clock, qualified by x_valid.
// Repetitions are separated by GAP_CYC idle cycles. A one-cycle done pulse follows
// the final bit. All outputs come straight from flops.
module seq_gen1 #(
  parameter int PAT_W   = 8,
  parameter int LEN_W   = 4,
  parameter int CNT_W   = 4,
  parameter int GAP_CYC = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [PAT_W-1:0] pattern,
  input  logic [LEN_W-1:0] len,
  input  logic [CNT_W-1:0] reps,
  input  logic             abort,
  output logic             x,
  output logic             x_valid,
  output logic             busy,
  output logic             done
);

  localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = (GAP_CYC > 0) ? GAP_W'(GAP_CYC - 1) : '0;
  localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(PAT_W);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_GAP,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [PAT_W-1:0] pat_q,   pat_d;
  logic [LEN_W-1:0] len_q,   len_d;
  logic [LEN_W-1:0] idx_q,   idx_d;
  logic [CNT_W-1:0] reps_q,  reps_d;
  logic [GAP_W-1:0] gap_q,   gap_d;
  logic             x_q,       x_d;
  logic             x_valid_q, x_valid_d;
  logic             busy_q,    busy_d;
  logic             done_q,    done_d;

  logic [LEN_W-1:0] len_eff;
  logic [CNT_W-1:0] reps_eff;

  // A length of zero or one beyond the pattern width means "send the whole pattern";
  // zero repetitions means one.
  always_comb begin
    len_eff  = ((len == '0) || (len > LEN_MAX)) ? LEN_MAX : len;
    reps_eff = (reps == '0) ? CNT_W'(1) : reps;
  end

  // State and datapath registers. Every flop is cleared by reset, so the block
  // restarts from IDLE with empty counters.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the values from before the edge, whatever the statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      pat_q   <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      reps_q  <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      reps_q  <= reps_d;
      gap_q   <= gap_d;
    end
  end

  // Next-state logic. idx_q is the index of the bit currently on x.
  // reps_q is the number of repetitions still owed, including the current one.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    state_d = state_q;
    pat_d   = pat_q;
    len_d   = len_q;
    idx_d   = idx_q;
    reps_d  = reps_q;
    gap_d   = gap_q;

    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      idx_d   = '0;
      reps_d  = '0;
      gap_d   = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            state_d = S_SEND;
            pat_d   = pattern;
            len_d   = len_eff;
            idx_d   = len_eff - 1'b1;
            reps_d  = reps_eff;
          end
        end
        S_SEND: begin
          if (idx_q != '0) begin
            idx_d = idx_q - 1'b1;
          end else begin
            if (reps_q != '0) reps_d = reps_q - 1'b1;
            if (reps_q > CNT_W'(1)) begin
              if (GAP_CYC > 0) begin
                state_d = S_GAP;
                gap_d   = GAP_LAST;
              end else begin
                idx_d = len_q - 1'b1;
              end
            end else begin
              state_d = S_DONE;
            end
          end
        end
        S_GAP: begin
          if (gap_q != '0) begin
            gap_d = gap_q - 1'b1;
          end else begin
            state_d = S_SEND;
            idx_d   = len_q - 1'b1;
          end
        end
        S_DONE: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // Output decode from the next state. The outputs are then registered, so
  // they line up with the state that is entered at the same edge.
  always_comb begin
    x_d       = (state_d == S_SEND) && |(pat_d & (PAT_W'(1) << idx_d));
    x_valid_d = (state_d == S_SEND);
    busy_d    = (state_d == S_SEND) || (state_d == S_GAP);
    done_d    = (state_d == S_DONE);
  end

  // Output registers. Reset clears them at once, without waiting for a clock.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x_q       <= 1'b0;
      x_valid_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      x_q       <= x_d;
      x_valid_q <= x_valid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign x       = x_q;
  assign x_valid = x_valid_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_seq_gen1.sv
// Testbench for seq_gen1. Two instances share the same stimulus: one with a
// two-cycle gap between repetitions and one with back-to-back repetitions.
// Expected waveforms are built cycle by cycle from the pattern, length and
// repetition rules.
module tb_seq_gen1;

  typedef logic [3:0] obs_t;        // {x, x_valid, busy, done}
  typedef obs_t       obs_q_t[$];

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] pattern = '0;
  logic [3:0] len = '0;
  logic [3:0] reps = '0;

  logic x_a, xv_a, busy_a, done_a;  // GAP_CYC = 2
  logic x_b, xv_b, busy_b, done_b;  // GAP_CYC = 0

  int n_checks = 0;
  int n_fail   = 0;

  obs_t obs_a[256];
  obs_t obs_b[256];

  seq_gen1 #(.PAT_W(8), .LEN_W(4), .CNT_W(4), .GAP_CYC(2)) u_gap2 (
    .clk(clk), .reset(rst_n), .start(start), .pattern(pattern), .len(len),
    .reps(reps), .abort(abort), .x(x_a), .x_valid(xv_a), .busy(busy_a), .done(done_a)
  );

  seq_gen1 #(.PAT_W(8), .LEN_W(4), .CNT_W(4), .GAP_CYC(0)) u_gap0 (
    .clk(clk), .reset(rst_n), .start(start), .pattern(pattern), .len(len),
    .reps(reps), .abort(abort), .x(x_b), .x_valid(xv_b), .busy(busy_b), .done(done_b)
  );

  always #5 clk = ~clk;

  // Reference waveform: entry c is the required output during cycle c, where
  // start is sampled at edge 0. Entry 0 is unused.
  function automatic obs_q_t model(input logic [7:0] pat, input int l_in, input int r_in,
                                   input int gap, input int abort_cyc);
    obs_q_t q;
    int l;
    int r;
    l = (l_in == 0 || l_in > 8) ? 8 : l_in;
    r = (r_in == 0) ? 1 : r_in;
    q.push_back(4'b0000);
    for (int k = 0; k < r; k++) begin
      for (int i = l - 1; i >= 0; i--) q.push_back({pat[i], 3'b110});
      if (k < r - 1) for (int g = 0; g < gap; g++) q.push_back(4'b0010);
    end
    q.push_back(4'b0001);
    if (abort_cyc > 0 && abort_cyc < q.size())
      while (q.size() > abort_cyc + 1) void'(q.pop_back());
    return q;
  endfunction

  function automatic obs_t exp_at(input obs_q_t q, input int c);
    return (c < q.size()) ? q[c] : 4'b0000;
  endfunction

  // Called at a falling edge. Start is sampled at the next rising edge (edge 0).
  // Outputs are recorded at each following falling edge. Inputs are scrambled
  // during the run to show that they are only captured at start.
  task automatic run_txn(input logic [7:0] pat, input logic [3:0] l, input logic [3:0] r,
                         input int abort_cyc, input int start_cyc, input int ncyc);
    pattern = pat; len = l; reps = r; start = 1'b1; abort = 1'b0;
    @(posedge clk);
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      obs_a[c] = {x_a, xv_a, busy_a, done_a};
      obs_b[c] = {x_b, xv_b, busy_b, done_b};
      start    = (c == start_cyc);
      abort    = (c == abort_cyc);
      pattern  = 8'($urandom);
      len      = 4'($urandom);
      reps     = 4'($urandom);
    end
    start = 1'b0;
    abort = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_checks++;
    if ({x_a, xv_a, busy_a, done_a} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_gap2: got %b want 0000", {x_a, xv_a, busy_a, done_a});
    end
    n_checks++;
    if ({x_b, xv_b, busy_b, done_b} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_gap0: got %b want 0000", {x_b, xv_b, busy_b, done_b});
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  // Runs one transaction and compares both instances against the model.
  task automatic test_txn(input string name, input logic [7:0] pat, input logic [3:0] l,
                          input logic [3:0] r, input int abort_cyc, input int start_cyc);
    obs_q_t qa;
    obs_q_t qb;
    int     ncyc;
    qa   = model(pat, int'(l), int'(r), 2, abort_cyc);
    qb   = model(pat, int'(l), int'(r), 0, abort_cyc);
    ncyc = ((qa.size() > qb.size()) ? qa.size() : qb.size()) + 2;
    run_txn(pat, l, r, abort_cyc, start_cyc, ncyc);
    for (int c = 1; c <= ncyc; c++) begin
      n_checks++;
      if (obs_a[c] !== exp_at(qa, c)) begin
        n_fail++;
        $display("FAIL %s gap2 cycle %0d: got %b want %b ({x,x_valid,busy,done})",
                 name, c, obs_a[c], exp_at(qa, c));
      end
      n_checks++;
      if (obs_b[c] !== exp_at(qb, c)) begin
        n_fail++;
        $display("FAIL %s gap0 cycle %0d: got %b want %b ({x,x_valid,busy,done})",
                 name, c, obs_b[c], exp_at(qb, c));
      end
    end
  endtask

  task automatic test_basic();
    test_txn("basic", 8'b0010_1010, 4'd6, 4'd1, 0, 0);
  endtask

  task automatic test_repeat_gap();
    test_txn("repeat_gap", 8'b0010_1010, 4'd6, 4'd2, 0, 0);
  endtask

  task automatic test_clamp();
    test_txn("clamp_len0", 8'hA5, 4'd0, 4'd0, 0, 0);
    test_txn("clamp_len12", 8'h3C, 4'd12, 4'd0, 0, 0);
    test_txn("len1_reps3", 8'h01, 4'd1, 4'd3, 0, 0);
  endtask

  task automatic test_abort_and_busy_start();
    test_txn("abort_c3", 8'b0010_1010, 4'd6, 4'd1, 3, 0);
    test_txn("abort_in_gap", 8'b0010_1010, 4'd6, 4'd2, 7, 0);
    test_txn("busy_start_c2", 8'b0010_1010, 4'd6, 4'd1, 0, 2);
  endtask

  task automatic test_reset_mid_run();
    pattern = 8'b0010_1010; len = 4'd6; reps = 4'd1; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({xv_a, busy_a} !== 2'b11) begin
      n_fail++;
      $display("FAIL pre_reset_active: got %b want 11", {xv_a, busy_a});
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({x_a, xv_a, busy_a, done_a} !== 4'b0000) begin
      n_fail++;
      $display("FAIL async_reset_gap2: got %b want 0000", {x_a, xv_a, busy_a, done_a});
    end
    n_checks++;
    if ({x_b, xv_b, busy_b, done_b} !== 4'b0000) begin
      n_fail++;
      $display("FAIL async_reset_gap0: got %b want 0000", {x_b, xv_b, busy_b, done_b});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      n_checks++;
      if ({x_a, xv_a, busy_a, done_a, x_b, xv_b, busy_b, done_b} !== 8'h00) begin
        n_fail++;
        $display("FAIL idle_after_reset: got %b want 00000000",
                 {x_a, xv_a, busy_a, done_a, x_b, xv_b, busy_b, done_b});
      end
    end
    test_txn("restart_after_reset", 8'b0010_1010, 4'd6, 4'd1, 0, 0);
  endtask

  task automatic test_back_to_back();
    test_txn("back_to_back", 8'b0000_0110, 4'd3, 4'd3, 0, 0);
  endtask

  task automatic test_random();
    obs_q_t     qa;
    obs_q_t     qb;
    logic [7:0] pat;
    logic [3:0] l;
    logic [3:0] r;
    int         last;
    int         ab;
    int         st;
    for (int n = 0; n < 20; n++) begin
      pat  = 8'($urandom);
      l    = 4'($urandom);
      r    = 4'($urandom_range(0, 4));
      qa   = model(pat, int'(l), int'(r), 2, 0);
      qb   = model(pat, int'(l), int'(r), 0, 0);
      last = ((qa.size() < qb.size()) ? qa.size() : qb.size()) - 1;
      ab   = 0;
      st   = 0;
      if ($urandom_range(0, 3) == 0) ab = $urandom_range(1, last);
      else if ($urandom_range(0, 1) == 0) st = $urandom_range(1, last);
      test_txn("random", pat, l, r, ab, st);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_repeat_gap();
    test_clamp();
    test_abort_and_busy_start();
    test_reset_mid_run();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_gen1.md
Name: seq_gen1

Overview:
- Serial bit-pattern generator. It is the transmit-side counterpart of the team's serial sequence detectors.
- Loads a programmable pattern (MSB-first, programmable length) and shifts it out one bit per clock on x, qualified by x_valid.
- Repeats the pattern a programmable number of times, with a fixed idle gap between repetitions.
- Used to drive detector inputs in-system and as a stimulus source for link bring-up.

Parameters:
- PAT_W, 8, maximum pattern length in bits.
- LEN_W, 4, width of the len input; must satisfy 2^LEN_W > PAT_W.
- CNT_W, 4, width of the reps input.
- GAP_CYC, 2, idle cycles (x=0, x_valid=0) between repetitions; 0 means back-to-back.

Ports:
- clk, input, 1, rising-edge clock; the block's only clock.
- reset, input, 1, asynchronous, active-low reset (0 = reset asserted).
- start, input, 1, request to begin a transmission; sampled only in IDLE.
- pattern, input, PAT_W, bits to send; bit len-1 is sent first, bit 0 last.
- len, input, LEN_W, number of bits per repetition; 0 or values above PAT_W are treated as PAT_W.
- reps, input, CNT_W, number of repetitions; 0 is treated as 1.
- abort, input, 1, synchronous cancel of a transmission in progress.
- x, output, 1, serial data bit.
- x_valid, output, 1, high on every cycle in which x carries a pattern bit.
- busy, output, 1, high from the cycle after start is accepted until the cycle before done.
- done, output, 1, one-cycle pulse after the final bit of the final repetition.

Behaviour:
- All outputs are registered.
- While reset=0, the block is asynchronously forced to: state IDLE, x=0, x_valid=0, busy=0, done=0, internal shift register, bit counter and repetition counter all 0.
- States:
  - IDLE: all outputs 0. If start=1 at a clock edge, capture pattern, effective len and effective reps, then go to SEND.
  - SEND: emit bit[idx] with x_valid=1 and busy=1. idx starts at len-1 and decrements by one per cycle.
  - GAP: x=0, x_valid=0, busy=1, held for exactly GAP_CYC cycles.
  - DONE: done=1, busy=0, x_valid=0 for one cycle, then go to IDLE.
- SEND exit, after the bit at idx=0:
  - if repetitions remaining > 1 and GAP_CYC > 0, go to GAP;
  - if repetitions remaining > 1 and GAP_CYC = 0, go directly to SEND with idx reloaded to len-1 from the captured copy;
  - otherwise go to DONE.
- GAP exit: go to SEND with idx reloaded to len-1.
- Latency:
  - start sampled at edge N gives the first bit on x during cycle N+1.
  - A transmission lasts len*reps + GAP_CYC*(reps-1) cycles from first bit to last bit.
  - done is high on the cycle immediately after the last bit.
- Inputs pattern, len and reps are captured only when start is accepted. Changing them mid-transmission has no effect.
- start is ignored in SEND, GAP and DONE. It is not queued.
- abort=1 in SEND, GAP or DONE forces IDLE at the next edge: x=0, x_valid=0, busy=0, and no done pulse. abort in IDLE has no effect.
- start and abort high together in IDLE: start wins, and the transmission begins.
- Asserting reset mid-transmission clears everything immediately. After reset is released, the block sits in IDLE until a new start.
- len=1: a single-bit SEND per repetition, and the GAP still applies between repetitions.
- Counters never wrap:
  - idx stops at 0;
  - the repetition counter decrements once per completed repetition and stops at 0.

Test Plan:
- Basic send: pattern=8'b0010_1010, len=6, reps=1, start at edge 0. Required: x = 1,0,1,0,1,0 in cycles 1-6 with x_valid=1; busy=1 in cycles 1-6; done=1 only in cycle 7; all outputs 0 from cycle 8.
- Repetitions with gap: same pattern, reps=2, GAP_CYC=2. Required: bits in cycles 1-6, x_valid=0 in cycles 7-8, bits again in cycles 9-14, done in cycle 15.
- Clamping: len=0, pattern=8'hA5, reps=0. Required: 8 bits 1,0,1,0,0,1,0,1 in cycles 1-8, then done in cycle 9.
- Abort and busy start: abort=1 in cycle 3 of the basic send. Required: all outputs 0 from cycle 4 and no done pulse. Also, a start pulse in cycle 2 of an unaborted run is ignored, so the sequence and done timing match the basic-send case.
- Reset mid-run: drive reset=0 mid-SEND, asynchronously between edges. Required: x, x_valid and busy drop immediately without waiting for a clock edge. After release, nothing happens until start; a new start sends the full pattern from the first bit.
- Back-to-back: GAP_CYC=0, len=3, pattern=3'b110, reps=3. Required: x = 1,1,0,1,1,0,1,1,0 in cycles 1-9, x_valid continuously high, done in cycle 10.
